// File: rtl/lif_pkg.sv
// Shared constants for the LIF neuron: reset defaults and config selectors.
package lif_pkg;

    localparam logic [7:0] TH_DEFAULT   = 8'd200;
    localparam logic [2:0] LEAK_DEFAULT = 3'd2;
    localparam logic [3:0] REFR_DEFAULT = 4'd2;

    typedef enum logic [1:0] {
        CFG_TH   = 2'd0,
        CFG_LEAK = 2'd1,
        CFG_REFR = 2'd2,
        CFG_NONE = 2'd3
    } cfg_sel_t;

    function automatic logic [7:0] leak_of(input logic [7:0] v, input logic [2:0] ls);
        return (ls == 3'd0) ? 8'd0 : (v >> ls);
    endfunction

endpackage

// File: rtl/lif_core.sv
// Membrane potential, refractory counter and spike register of one LIF neuron.
import lif_pkg::*;

module lif_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       hold,
    input  logic [7:0] cur,
    input  logic [7:0] th,
    input  logic [2:0] ls,
    input  logic [3:0] rp,
    output logic [7:0] v,
    output logic       spike
);

    logic [3:0] rcnt;
    logic [8:0] sum;
    logic       fire;

    // 9-bit sum cannot wrap: v - leak <= 255 and cur <= 255
    always_comb begin
        sum  = {1'b0, v} - {1'b0, leak_of(v, ls)} + {1'b0, cur};
        fire = (sum >= {1'b0, th});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v     <= 8'd0;
            rcnt  <= 4'd0;
            spike <= 1'b0;
        end else if (!ena || hold) begin
            spike <= 1'b0;
        end else if (rcnt != 4'd0) begin
            v     <= 8'd0;
            rcnt  <= rcnt - 4'd1;
            spike <= 1'b0;
        end else if (fire) begin
            v     <= 8'd0;
            rcnt  <= rp;
            spike <= 1'b1;
        end else begin
            v     <= sum[7:0];
            spike <= 1'b0;
        end
    end

endmodule

// File: rtl/tt_um_xgamer1999_lif.sv
// TinyTapeout top: config registers, uio decode and output packing for the LIF neuron.
import lif_pkg::*;

module tt_um_xgamer1999_lif (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       cfg_we;
    cfg_sel_t   cfg_sel;
    logic [7:0] th;
    logic [2:0] ls;
    logic [3:0] rp;
    logic [7:0] v;
    logic       spike;
    logic       unused_bits;

    assign cfg_we      = uio_in[0];
    assign cfg_sel     = cfg_sel_t'(uio_in[2:1]);
    assign unused_bits = ^{uio_in[7:3], v[0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            th <= TH_DEFAULT;
            ls <= LEAK_DEFAULT;
            rp <= REFR_DEFAULT;
        end else if (ena && cfg_we) begin
            unique case (cfg_sel)
                CFG_TH:   th <= ui_in;
                CFG_LEAK: ls <= ui_in[2:0];
                CFG_REFR: rp <= ui_in[3:0];
                CFG_NONE: ;
            endcase
        end
    end

    lif_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .hold  (cfg_we),
        .cur   (ui_in),
        .th    (th),
        .ls    (ls),
        .rp    (rp),
        .v     (v),
        .spike (spike)
    );

    assign uo_out  = {spike, v[7:1]};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_xgamer1999_lif.sv
// Self-checking bench for the LIF neuron against a behavioural neuron model.
module tb_tt_um_xgamer1999_lif;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int m_v, m_th, m_ls, m_rp, m_refr;
    bit m_spike;

    tt_um_xgamer1999_lif dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_out();
        logic [7:0] vb;
        vb = m_v[7:0];
        return {m_spike, vb[7:1]};
    endfunction

    task automatic model_step(input bit rst, input bit en, input bit we,
                              input int sel, input int cur);
        int s;
        if (!rst) begin
            m_v = 0; m_spike = 0; m_refr = 0;
            m_th = 200; m_ls = 2; m_rp = 2;
        end else if (!en) begin
            m_spike = 0;
        end else if (we) begin
            m_spike = 0;
            if (sel == 0) m_th = cur;
            else if (sel == 1) m_ls = cur % 8;
            else if (sel == 2) m_rp = cur % 16;
        end else if (m_refr > 0) begin
            m_v = 0; m_refr = m_refr - 1; m_spike = 0;
        end else begin
            s = m_v - (m_v / (2 ** m_ls)) * ((m_ls != 0) ? 1 : 0) + cur;
            if (m_ls == 0) s = m_v + cur;
            if (s >= m_th) begin
                m_spike = 1; m_v = 0; m_refr = m_rp;
            end else begin
                m_spike = 0; m_v = s;
            end
        end
    endtask

    // drive one cycle, advance the model, sample 1 time unit after the edge
    task automatic tick(input bit rst, input bit en, input bit we,
                        input int sel, input int cur);
        logic [7:0] sb;
        sb = sel[7:0];
        rst_n  = rst;
        ena    = en;
        ui_in  = cur[7:0];
        uio_in = {5'b10110, sb[1:0], we};
        @(posedge clk);
        model_step(rst, en, we, sel, cur);
        #1;
    endtask

    task automatic do_reset();
        tick(0, 1, 1, 0, 8'h55);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got=%h exp=00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL uio_const got=%h/%h exp=00/00", uio_out, uio_oe);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1, 1, 0, 0, 0);
            checks++;
            if (uo_out !== 8'h00) begin
                errors++;
                $display("FAIL idle_zero cyc=%0d got=%h exp=00", i, uo_out);
            end
        end
    endtask

    task automatic test_defaults_100();
        logic [7:0] exp_seq [6];
        exp_seq = '{8'd50, 8'd87, 8'h80, 8'h00, 8'h00, 8'd50};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1, 1, 0, 0, 100);
            checks++;
            if (uo_out !== exp_seq[i] || uo_out !== model_out()) begin
                errors++;
                $display("FAIL i100 edge=%0d got=%h exp=%h", i + 1, uo_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_settle_40();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            tick(1, 1, 0, 0, 40);
            checks++;
            if (uo_out[7] !== 1'b0 || uo_out !== model_out()) begin
                errors++;
                $display("FAIL i40 cyc=%0d got=%h exp=%h", i, uo_out, model_out());
            end
        end
        checks++;
        if (uo_out !== 8'd80) begin
            errors++;
            $display("FAIL i40_settle got=%h exp=50", uo_out);
        end
    endtask

    task automatic test_ls0_count();
        logic [7:0] k8;
        do_reset();
        tick(1, 1, 1, 1, 0);
        for (int k = 1; k <= 200; k++) begin
            tick(1, 1, 0, 0, 1);
            k8 = k[7:0];
            checks++;
            if (k < 200 && uo_out !== {1'b0, k8[7:1]}) begin
                errors++;
                $display("FAIL ls0_count k=%0d got=%h exp=%h", k, uo_out, {1'b0, k8[7:1]});
            end else if (k == 200 && uo_out !== 8'h80) begin
                errors++;
                $display("FAIL ls0_spike got=%h exp=80", uo_out);
            end
        end
    endtask

    task automatic test_th10_ena();
        do_reset();
        tick(1, 1, 1, 0, 10);
        tick(1, 1, 0, 0, 10);
        checks++;
        if (uo_out !== 8'h80) begin
            errors++;
            $display("FAIL th10_spike got=%h exp=80", uo_out);
        end
        tick(1, 0, 0, 0, 10);
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL ena0_clear got=%h exp=00", uo_out);
        end
        do_reset();
        tick(1, 1, 0, 0, 100);
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 0, $urandom_range(255));
            checks++;
            if (uo_out !== 8'd50) begin
                errors++;
                $display("FAIL ena0_hold cyc=%0d got=%h exp=32", i, uo_out);
            end
        end
        tick(1, 1, 0, 0, 100);
        checks++;
        if (uo_out !== 8'd87) begin
            errors++;
            $display("FAIL ena_resume got=%h exp=57", uo_out);
        end
    endtask

    task automatic test_reset_refractory();
        logic [7:0] exp_seq [3];
        exp_seq = '{8'd50, 8'd87, 8'h80};
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 100);
        tick(0, 1, 0, 0, 100);
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL refr_reset got=%h exp=00", uo_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 0, 100);
            checks++;
            if (uo_out !== exp_seq[i]) begin
                errors++;
                $display("FAIL post_reset edge=%0d got=%h exp=%h", i + 1, uo_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1, 1, 1, 2, 0);
        tick(1, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(1, 1, 0, 0, $urandom_range(255));
            checks++;
            if (uo_out !== 8'h80) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%h exp=80", i, uo_out);
            end
        end
    endtask

    task automatic test_random();
        bit r, e, w;
        int sel, cur;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(99) != 0);
            e   = ($urandom_range(9) != 0);
            w   = ($urandom_range(9) == 0);
            sel = $urandom_range(3);
            cur = w ? ((sel == 0) ? $urandom_range(60, 255) : $urandom_range(255))
                    : $urandom_range(120);
            tick(r, e, w, sel, cur);
            checks++;
            if (uo_out !== model_out()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, uo_out, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults_100();
        test_settle_40();
        test_ls0_count();
        test_th10_ena();
        test_reset_refractory();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
